// File: rtl/game_clock_pkg.sv
// Shared types and widths for the scoreboard game/shot clock controller.
package game_clock_pkg;

  localparam int unsigned MIN_W  = 4;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned SHOT_W = 5;
  localparam int unsigned PER_W  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPause,
    StPeriodEnd,
    StGameOver
  } state_e;

  function automatic logic [MIN_W-1:0] reload_min(input int unsigned period_sec);
    return MIN_W'(period_sec / 60);
  endfunction

  function automatic logic [SEC_W-1:0] reload_sec(input int unsigned period_sec);
    return SEC_W'(period_sec % 60);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts only while enabled, holds otherwise, pulses tick on wrap.
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == CntMax);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_clock_ctrl.sv
// Basketball timing controller: period countdown, shot clock, period sequencing and buzzer.
module game_clock_ctrl import game_clock_pkg::*; #(
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned PERIOD_SEC  = 600,
  parameter int unsigned SHOT_SEC    = 24,
  parameter int unsigned NUM_PERIODS = 4,
  parameter int unsigned BUZZ_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              shot_reset,
  input  logic              next_period,
  output logic [MIN_W-1:0]  game_min,
  output logic [SEC_W-1:0]  game_sec,
  output logic [SHOT_W-1:0] shot_sec,
  output logic [PER_W-1:0]  period,
  output logic              running,
  output logic              buzzer,
  output logic              game_over
);

  localparam logic [MIN_W-1:0]  ReloadMin  = reload_min(PERIOD_SEC);
  localparam logic [SEC_W-1:0]  ReloadSec  = reload_sec(PERIOD_SEC);
  localparam logic [SHOT_W-1:0] ReloadShot = SHOT_W'(SHOT_SEC);
  localparam logic [PER_W-1:0]  LastPeriod = PER_W'(NUM_PERIODS);
  localparam int unsigned       BuzzW      = $clog2(BUZZ_CYCLES + 1);
  localparam logic [BuzzW-1:0]  BuzzLoad   = BuzzW'(BUZZ_CYCLES);

  state_e            state_q, state_d;
  logic [MIN_W-1:0]  min_q, min_d, min_dec;
  logic [SEC_W-1:0]  sec_q, sec_d, sec_dec;
  logic [SHOT_W-1:0] shot_q, shot_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic [BuzzW-1:0]  buzz_cnt_q, buzz_cnt_d;
  logic              buzzer_q, buzzer_d;
  logic              running_q, running_d;
  logic              game_over_q, game_over_d;
  logic              tick, presc_clr, buzz_evt;
  logic              game_nonzero, game_hits_zero, shot_hits_zero, cmd_ok;

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == StRun),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    shot_d    = shot_q;
    period_d  = period_q;
    presc_clr = 1'b0;
    buzz_evt  = 1'b0;

    if (sec_q == '0) begin
      min_dec = min_q - MIN_W'(1);
      sec_dec = SEC_W'(59);
    end else begin
      min_dec = min_q;
      sec_dec = sec_q - SEC_W'(1);
    end
    game_nonzero   = (min_q != '0) || (sec_q != '0);
    game_hits_zero = (min_dec == '0) && (sec_dec == '0);
    // A coinciding reload pre-empts the shot decrement, so it cannot expire.
    shot_hits_zero = (shot_q == SHOT_W'(1)) && !shot_reset;
    cmd_ok         = (state_q == StIdle) || (state_q == StRun) || (state_q == StPause);

    if (tick && game_nonzero) begin
      min_d = min_dec;
      sec_d = sec_dec;
      if (shot_q != '0) shot_d = shot_q - SHOT_W'(1);
    end
    if (shot_reset && cmd_ok) shot_d = ReloadShot;

    unique case (state_q)
      StIdle, StPause: begin
        if (start && !stop) state_d = StRun;
      end
      StRun: begin
        if (tick && game_hits_zero) begin
          buzz_evt = 1'b1;
          state_d  = (period_q < LastPeriod) ? StPeriodEnd : StGameOver;
        end else if (tick && shot_hits_zero) begin
          buzz_evt = 1'b1;
          state_d  = StPause;
        end else if (stop) begin
          state_d = StPause;
        end
      end
      StPeriodEnd: begin
        if (next_period) begin
          period_d  = period_q + PER_W'(1);
          min_d     = ReloadMin;
          sec_d     = ReloadSec;
          shot_d    = ReloadShot;
          presc_clr = 1'b1;
          state_d   = StIdle;
        end
      end
      StGameOver: ;
      default: state_d = StIdle;
    endcase

    if (buzz_evt) begin
      buzz_cnt_d = BuzzLoad;
    end else if (buzz_cnt_q != '0) begin
      buzz_cnt_d = buzz_cnt_q - BuzzW'(1);
    end else begin
      buzz_cnt_d = '0;
    end
    buzzer_d    = (buzz_cnt_d != '0);
    running_d   = (state_d == StRun);
    game_over_d = (state_d == StGameOver);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      min_q       <= ReloadMin;
      sec_q       <= ReloadSec;
      shot_q      <= ReloadShot;
      period_q    <= PER_W'(1);
      buzz_cnt_q  <= '0;
      buzzer_q    <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      shot_q      <= shot_d;
      period_q    <= period_d;
      buzz_cnt_q  <= buzz_cnt_d;
      buzzer_q    <= buzzer_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  assign game_min  = min_q;
  assign game_sec  = sec_q;
  assign shot_sec  = shot_q;
  assign period    = period_q;
  assign running   = running_q;
  assign buzzer    = buzzer_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed bench: three controller configurations driven one at a time from a shared clock.
module tb_game_clock_ctrl;

  localparam logic [3:0] CStart = 4'b0001;
  localparam logic [3:0] CStop  = 4'b0010;
  localparam logic [3:0] CShot  = 4'b0100;
  localparam logic [3:0] CNext  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmd  [3];
  logic [3:0] gmin [3];
  logic [5:0] gsec [3];
  logic [4:0] shot [3];
  logic [2:0] per  [3];
  logic       run  [3];
  logic       buz  [3];
  logic       gov  [3];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // a: 10:00 periods, b: 0:24 period, c: single 0:03 period
  game_clock_ctrl #(
    .TICK_DIV(4), .PERIOD_SEC(600), .SHOT_SEC(24), .NUM_PERIODS(4), .BUZZ_CYCLES(5)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(cmd[0][0]), .stop(cmd[0][1]), .shot_reset(cmd[0][2]),
    .next_period(cmd[0][3]), .game_min(gmin[0]), .game_sec(gsec[0]), .shot_sec(shot[0]),
    .period(per[0]), .running(run[0]), .buzzer(buz[0]), .game_over(gov[0])
  );

  game_clock_ctrl #(
    .TICK_DIV(4), .PERIOD_SEC(24), .SHOT_SEC(24), .NUM_PERIODS(4), .BUZZ_CYCLES(5)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(cmd[1][0]), .stop(cmd[1][1]), .shot_reset(cmd[1][2]),
    .next_period(cmd[1][3]), .game_min(gmin[1]), .game_sec(gsec[1]), .shot_sec(shot[1]),
    .period(per[1]), .running(run[1]), .buzzer(buz[1]), .game_over(gov[1])
  );

  game_clock_ctrl #(
    .TICK_DIV(4), .PERIOD_SEC(3), .SHOT_SEC(24), .NUM_PERIODS(1), .BUZZ_CYCLES(5)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(cmd[2][0]), .stop(cmd[2][1]), .shot_reset(cmd[2][2]),
    .next_period(cmd[2][3]), .game_min(gmin[2]), .game_sec(gsec[2]), .shot_sec(shot[2]),
    .period(per[2]), .running(run[2]), .buzzer(buz[2]), .game_over(gov[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_clock(input int i, input string tag, input int m, input int s, input int sh);
    check({tag, ".min"}, 32'(gmin[i]), m);
    check({tag, ".sec"}, 32'(gsec[i]), s);
    check({tag, ".shot"}, 32'(shot[i]), sh);
  endtask

  task automatic chk_flags(input int i, input string tag, input int r, input int b, input int g);
    check({tag, ".running"}, 32'(run[i]), r);
    check({tag, ".buzzer"}, 32'(buz[i]), b);
    check({tag, ".game_over"}, 32'(gov[i]), g);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int i, input logic [3:0] c);
    cmd[i] = c;
    cyc(1);
    cmd[i] = '0;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cmd[i] = '0;

    // 1: reset values, first tick on the 4th RUN cycle
    do_reset;
    chk_clock(0, "rst_a", 10, 0, 24);
    chk_flags(0, "rst_a", 0, 0, 0);
    check("rst_a.period", 32'(per[0]), 1);
    chk_clock(1, "rst_b", 0, 24, 24);
    chk_clock(2, "rst_c", 0, 3, 24);
    pulse(0, CStart);
    check("t1.running", 32'(run[0]), 1);
    cyc(3);
    chk_clock(0, "t1.pre_tick", 10, 0, 24);
    cyc(1);
    chk_clock(0, "t1.tick", 9, 59, 23);
    check("t1.buzzer", 32'(buz[0]), 0);

    // 2: pause keeps the partial second
    cyc(1);
    pulse(0, CStop);
    check("t2.paused", 32'(run[0]), 0);
    cyc(10);
    chk_clock(0, "t2.frozen", 9, 59, 23);
    pulse(0, CStart);
    check("t2.resumed", 32'(run[0]), 1);
    cyc(1);
    check("t2.no_tick_yet", 32'(gsec[0]), 59);
    cyc(1);
    chk_clock(0, "t2.tick", 9, 58, 22);
    pulse(0, CStart | CStop);
    check("t2.stop_wins", 32'(run[0]), 0);

    // 3: shot clock expiry
    do_reset;
    pulse(0, CStart);
    cyc(95);
    chk_clock(0, "t3.before", 9, 37, 1);
    chk_flags(0, "t3.before", 1, 0, 0);
    cyc(1);
    chk_clock(0, "t3.expire", 9, 36, 0);
    chk_flags(0, "t3.expire", 0, 1, 0);
    cyc(4);
    check("t3.buzz_last", 32'(buz[0]), 1);
    cyc(1);
    check("t3.buzz_off", 32'(buz[0]), 0);
    check("t3.game_held", 32'(gsec[0]), 36);

    // 4: shot reload beats a coinciding tick
    pulse(0, CShot);
    check("t4.reload_pause", 32'(shot[0]), 24);
    pulse(0, CStart);
    cyc(56);
    chk_clock(0, "t4.at10", 9, 22, 10);
    cyc(3);
    pulse(0, CShot);
    chk_clock(0, "t4.reload_tick", 9, 21, 24);

    // 5: simultaneous game and shot expiry, then next period
    do_reset;
    pulse(1, CStart);
    cyc(95);
    chk_clock(1, "t5.before", 0, 1, 1);
    cyc(1);
    chk_clock(1, "t5.expire", 0, 0, 0);
    chk_flags(1, "t5.expire", 0, 1, 0);
    check("t5.period1", 32'(per[1]), 1);
    cyc(4);
    check("t5.buzz_last", 32'(buz[1]), 1);
    cyc(1);
    check("t5.buzz_off", 32'(buz[1]), 0);
    pulse(1, CStart);
    check("t5.start_ignored", 32'(run[1]), 0);
    pulse(1, CShot);
    check("t5.shot_ignored", 32'(shot[1]), 0);
    pulse(1, CNext);
    check("t5.period2", 32'(per[1]), 2);
    chk_clock(1, "t5.reloaded", 0, 24, 24);
    check("t5.idle", 32'(run[1]), 0);
    pulse(1, CStart);
    cyc(3);
    check("t5.presc_cleared", 32'(gsec[1]), 24);
    cyc(1);
    check("t5.first_tick", 32'(gsec[1]), 23);

    // 6: game over is terminal; async reset mid-buzzer
    do_reset;
    pulse(2, CStart);
    cyc(11);
    chk_clock(2, "t6.before", 0, 1, 22);
    cyc(1);
    chk_clock(2, "t6.over", 0, 0, 21);
    chk_flags(2, "t6.over", 0, 1, 1);
    pulse(2, CStart);
    chk_flags(2, "t6.start_ign", 0, 1, 1);
    pulse(2, CShot);
    check("t6.shot_ign", 32'(shot[2]), 21);
    pulse(2, CNext);
    check("t6.next_ign", 32'(per[2]), 1);
    check("t6.still_buzz", 32'(buz[2]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_clock(2, "t6.async_rst", 0, 3, 24);
    chk_flags(2, "t6.async_rst", 0, 0, 0);
    check("t6.async_period", 32'(per[2]), 1);
    #1 rst_n = 1'b1;
    cyc(1);
    chk_flags(2, "t6.after_rst", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
